// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: drives an 8-bit signed MAC through one dot product.
// The host fills an operand-pair buffer. On start the sequencer clears the MAC,
// issues vec_len pairs, waits out the multiplier pipeline, finalizes, and then
// captures the MAC's 16-bit result.
// All outputs are registered: each one is computed from the next state.
// Optional feature: define MAC_SEQ_TIMEOUT_EN to abort a WAIT that lasts longer
// than TIMEOUT cycles. The abort pulses err and mac_rst.
module mac_dot_sequencer #(
  parameter int DEPTH    = 16,
  parameter int MULT_LAT = 3,
  parameter int II       = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [7:0]                 wr_a,
  input  logic [7:0]                 wr_b,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     vec_len,
  output logic                       busy,
  output logic [15:0]                result,
  output logic                       result_valid,
  output logic                       err,
  output logic                       mac_rst,
  output logic                       mac_en,
  output logic [7:0]                 mac_a,
  output logic [7:0]                 mac_b,
  output logic                       mac_finalize,
  input  logic [15:0]                mac_out,
  input  logic                       mac_out_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  // One shared counter serves the issue gap, the drain wait and the timeout.
  localparam int MAX_A   = (II > MULT_LAT + 1) ? II : MULT_LAT + 1;
  localparam int CNT_MAX = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_FINAL, S_WAIT
  } state_t;

  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];

  state_t        state_r, state_s;
  logic [NW-1:0] n_r, n_s;
  logic [AW-1:0] idx_r, idx_s, idx_inc_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          busy_r, busy_s;
  logic [15:0]   result_r, result_s;
  logic          result_valid_r, result_valid_s;
  logic          err_r, err_s;
  logic          mac_rst_r, mac_rst_s;
  logic          mac_en_r, mac_en_s;
  logic [7:0]    mac_a_r, mac_a_s;
  logic [7:0]    mac_b_r, mac_b_s;
  logic          mac_finalize_r, mac_finalize_s;

  assign idx_inc_s = idx_r + AW'(1);

  // Operand buffer write port. Writes are locked out while a run is in flight.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_r) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  end

  // Next-state logic. It also computes the value each output takes next cycle.
  always_comb begin
    state_s        = state_r;
    n_s            = n_r;
    idx_s          = idx_r;
    cnt_s          = cnt_r;
    result_s       = result_r;
    result_valid_s = 1'b0;
    err_s          = 1'b0;
    mac_rst_s      = 1'b0;
    mac_en_s       = 1'b0;
    mac_finalize_s = 1'b0;
    mac_a_s        = mac_a_r;
    mac_b_s        = mac_b_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if ((vec_len != NW'(0)) && (vec_len <= NW'(DEPTH))) begin
            state_s   = S_CLEAR;
            n_s       = vec_len;
            mac_rst_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        // Pair 0 goes out in the first ISSUE cycle.
        state_s  = S_ISSUE;
        idx_s    = '0;
        cnt_s    = '0;
        mac_en_s = 1'b1;
        mac_a_s  = mem_a[{AW{1'b0}}];
        mac_b_s  = mem_b[{AW{1'b0}}];
      end
      S_ISSUE: begin
        if (cnt_r == CW'(II - 1)) begin
          if ({1'b0, idx_r} == (n_r - NW'(1))) begin
            state_s = S_DRAIN;
            cnt_s   = '0;
          end else begin
            idx_s    = idx_inc_s;
            cnt_s    = '0;
            mac_en_s = 1'b1;
            mac_a_s  = mem_a[idx_inc_s];
            mac_b_s  = mem_b[idx_inc_s];
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_r == CW'(MULT_LAT)) begin
          state_s        = S_FINAL;
          mac_finalize_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_FINAL: begin
        state_s = S_WAIT;
        cnt_s   = '0;
      end
      S_WAIT: begin
        if (mac_out_valid) begin
          state_s        = S_IDLE;
          result_s       = mac_out;
          result_valid_s = 1'b1;
        end else begin
`ifdef MAC_SEQ_TIMEOUT_EN
          if (cnt_r == CW'(TIMEOUT - 1)) begin
            state_s   = S_IDLE;
            err_s     = 1'b1;
            mac_rst_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
`else
          state_s = S_WAIT;
`endif
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State, counters and registered outputs. Reset leaves the MAC held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      n_r            <= '0;
      idx_r          <= '0;
      cnt_r          <= '0;
      busy_r         <= 1'b0;
      result_r       <= 16'd0;
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
      mac_rst_r      <= 1'b1;
      mac_en_r       <= 1'b0;
      mac_a_r        <= 8'd0;
      mac_b_r        <= 8'd0;
      mac_finalize_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      n_r            <= n_s;
      idx_r          <= idx_s;
      cnt_r          <= cnt_s;
      busy_r         <= busy_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      err_r          <= err_s;
      mac_rst_r      <= mac_rst_s;
      mac_en_r       <= mac_en_s;
      mac_a_r        <= mac_a_s;
      mac_b_r        <= mac_b_s;
      mac_finalize_r <= mac_finalize_s;
    end
  end

  assign busy         = busy_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign err          = err_r;
  assign mac_rst      = mac_rst_r;
  assign mac_en       = mac_en_r;
  assign mac_a        = mac_a_r;
  assign mac_b        = mac_b_r;
  assign mac_finalize = mac_finalize_r;

endmodule
